// File: rtl/conv_same_idx_seq.sv
// conv_same_idx_seq: walks every "same"-mode output sample of a 1-D convolution
// and, for each one, every valid (x, y) operand pair. It drives the operand read
// addresses and the MAC handshake, and emits value/enable/clear strobes for the
// downstream same-index register. All outputs are registered.
module conv_same_idx_seq (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_start,
  input  logic [4:0] i_size_x,
  input  logic [4:0] i_size_y,
  input  logic       i_mac_ready,
  output logic [4:0] o_x_addr,
  output logic [4:0] o_y_addr,
  output logic       o_mac_valid,
  output logic       o_acc_clr,
  output logic [4:0] o_same_ind_val,
  output logic       o_same_ind_en,
  output logic       o_same_ind_clr,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    INNER = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     r_state;
  logic [4:0] r_nx;
  logic [4:0] r_ny;
  logic [5:0] r_i;
  logic [5:0] r_j;

  logic [5:0] w_nym1;
  logic [5:0] w_nxm1;
  logic [5:0] w_offset;
  logic [5:0] w_jmin;
  logic [5:0] w_jmax;
  logic [5:0] w_ilast;
  logic [5:0] w_jnext;
  logic [5:0] w_startOffset;
  logic [4:0] w_yFirst;
  logic [4:0] w_yNext;
  logic [4:0] w_sameVal;
  logic       w_sizeZero;

  // Index arithmetic: the j range for the current full-convolution index i is
  // clipped on both ends so y_addr stays within 0..NY-1 and x_addr within 0..NX-1.
  assign w_nym1        = {1'b0, r_ny} - 6'd1;
  assign w_nxm1        = {1'b0, r_nx} - 6'd1;
  assign w_offset      = w_nym1 >> 1;
  assign w_jmin        = (r_i >= w_nym1) ? (r_i - w_nym1) : 6'd0;
  assign w_jmax        = (r_i < w_nxm1) ? r_i : w_nxm1;
  assign w_ilast       = w_offset + w_nxm1;
  assign w_jnext       = r_j + 6'd1;
  assign w_startOffset = ({1'b0, i_size_y} - 6'd1) >> 1;
  assign w_yFirst      = r_i[4:0] - w_jmin[4:0];
  assign w_yNext       = r_i[4:0] - w_jnext[4:0];
  assign w_sameVal     = r_i[4:0] - w_offset[4:0];
  assign w_sizeZero    = (i_size_x == 5'd0) || (i_size_y == 5'd0);

  // Sequencer FSM: state, counters and every output are registered together so
  // each output reflects the state the FSM has just entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= IDLE;
      r_nx           <= 5'd0;
      r_ny           <= 5'd0;
      r_i            <= 6'd0;
      r_j            <= 6'd0;
      o_x_addr       <= 5'd0;
      o_y_addr       <= 5'd0;
      o_mac_valid    <= 1'b0;
      o_acc_clr      <= 1'b0;
      o_same_ind_val <= 5'd0;
      o_same_ind_en  <= 1'b0;
      o_same_ind_clr <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_sizeZero) begin
              r_state <= DONE;
              o_done  <= 1'b1;
            end else begin
              r_nx           <= i_size_x;
              r_ny           <= i_size_y;
              r_i            <= w_startOffset;
              r_state        <= SETUP;
              o_acc_clr      <= 1'b1;
              o_busy         <= 1'b1;
              o_same_ind_clr <= 1'b1;
            end
          end
        end
        SETUP: begin
          r_j            <= w_jmin;
          r_state        <= INNER;
          o_acc_clr      <= 1'b0;
          o_same_ind_clr <= 1'b0;
          o_mac_valid    <= 1'b1;
          o_x_addr       <= w_jmin[4:0];
          o_y_addr       <= w_yFirst;
        end
        INNER: begin
          if (i_mac_ready) begin
            if (r_j == w_jmax) begin
              r_state        <= STORE;
              o_mac_valid    <= 1'b0;
              o_x_addr       <= 5'd0;
              o_y_addr       <= 5'd0;
              o_same_ind_en  <= 1'b1;
              o_same_ind_val <= w_sameVal;
            end else begin
              r_j      <= w_jnext;
              o_x_addr <= w_jnext[4:0];
              o_y_addr <= w_yNext;
            end
          end
        end
        STORE: begin
          o_same_ind_en  <= 1'b0;
          o_same_ind_val <= 5'd0;
          if (r_i == w_ilast) begin
            r_state <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_i       <= r_i + 6'd1;
            r_state   <= SETUP;
            o_acc_clr <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          r_nx    <= 5'd0;
          r_ny    <= 5'd0;
          r_i     <= 6'd0;
          r_j     <= 6'd0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_same_idx_seq.sv
// tb_conv_same_idx_seq: drives sequences of various sizes and ready patterns and
// compares the observed pairs, store strobes and completion timing against an
// index-arithmetic reference model.
module tb_conv_same_idx_seq;

  logic       clk;
  logic       rstn;
  logic       i_start;
  logic [4:0] i_size_x;
  logic [4:0] i_size_y;
  logic       i_mac_ready;
  logic [4:0] o_x_addr;
  logic [4:0] o_y_addr;
  logic       o_mac_valid;
  logic       o_acc_clr;
  logic [4:0] o_same_ind_val;
  logic       o_same_ind_en;
  logic       o_same_ind_clr;
  logic       o_busy;
  logic       o_done;

  int numCompared = 0;
  int numMismatched = 0;

  conv_same_idx_seq dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_start        (i_start),
    .i_size_x       (i_size_x),
    .i_size_y       (i_size_y),
    .i_mac_ready    (i_mac_ready),
    .o_x_addr       (o_x_addr),
    .o_y_addr       (o_y_addr),
    .o_mac_valid    (o_mac_valid),
    .o_acc_clr      (o_acc_clr),
    .o_same_ind_val (o_same_ind_val),
    .o_same_ind_en  (o_same_ind_en),
    .o_same_ind_clr (o_same_ind_clr),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every output packed into one word, for the "everything is zero" checks.
  function automatic int allOutputs();
    return int'({o_x_addr, o_y_addr, o_mac_valid, o_acc_clr, o_same_ind_val,
                 o_same_ind_en, o_same_ind_clr, o_busy, o_done});
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one sequence. mode 0: ready always high; 1: ready toggles every INNER
  // cycle starting high; 2: random ready. pokeStart also re-asserts start while
  // busy and in the DONE cycle, both of which must be ignored.
  task automatic applyStimulus(input int nx, input int ny, input int mode, input bit pokeStart);
    int expPairs[$];
    int gotPairs[$];
    int gotVals[$];
    int off, jmin, jmax, sumCycles, stalls, cyc, doneCyc;
    int accClrCnt, sameClrCnt, overlapCnt, busyErrCnt;
    bit nonEmpty, rdyToggle, rdy;

    // Reference model: enumerate pairs from the index rules.
    nonEmpty  = (nx != 0) && (ny != 0);
    sumCycles = 0;
    if (nonEmpty) begin
      off = (ny - 1) / 2;
      for (int i = off; i <= off + nx - 1; i++) begin
        jmin = (i >= ny - 1) ? i - (ny - 1) : 0;
        jmax = (i < nx - 1) ? i : nx - 1;
        for (int j = jmin; j <= jmax; j++) expPairs.push_back(j * 32 + (i - j));
        sumCycles += (jmax - jmin + 1) + 2;
      end
    end

    @(negedge clk);
    i_size_x    = 5'(nx);
    i_size_y    = 5'(ny);
    i_start     = 1'b1;
    i_mac_ready = 1'b1;

    stalls = 0; cyc = 0; doneCyc = -1; rdyToggle = 1'b1;
    accClrCnt = 0; sameClrCnt = 0; overlapCnt = 0; busyErrCnt = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      if (pokeStart && cyc == 3) begin
        i_start  = 1'b1;
        i_size_x = 5'd7;
        i_size_y = 5'd7;
      end
      if (mode == 1) begin
        if (o_mac_valid) begin
          rdy = rdyToggle;
          rdyToggle = !rdyToggle;
        end else rdy = 1'b1;
      end else if (mode == 2) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      i_mac_ready = rdy;
      if (o_mac_valid && rdy) gotPairs.push_back(int'(o_x_addr) * 32 + int'(o_y_addr));
      if (o_mac_valid && !rdy) stalls++;
      if (o_same_ind_en) gotVals.push_back(int'(o_same_ind_val));
      if (o_acc_clr) accClrCnt++;
      if (o_same_ind_clr) sameClrCnt++;
      if (o_same_ind_clr && o_same_ind_en) overlapCnt++;
      if (o_busy != (nonEmpty && !o_done)) busyErrCnt++;
      if (o_done) begin
        doneCyc = cyc;
        break;
      end
    end
    if (doneCyc < 0) checkOutput("timeoutNoDone", cyc, -1);

    checkOutput("doneCycle", doneCyc, nonEmpty ? sumCycles + 1 + stalls : 1);
    checkOutput("pairCount", gotPairs.size(), expPairs.size());
    for (int k = 0; k < expPairs.size() && k < gotPairs.size(); k++)
      checkOutput($sformatf("pair%0d(x*32+y)", k), gotPairs[k], expPairs[k]);
    checkOutput("storeCount", gotVals.size(), nonEmpty ? nx : 0);
    for (int k = 0; k < gotVals.size() && k < nx; k++)
      checkOutput($sformatf("sameVal%0d", k), gotVals[k], k);
    checkOutput("accClrCount", accClrCnt, nonEmpty ? nx : 0);
    checkOutput("sameClrCount", sameClrCnt, nonEmpty ? 1 : 0);
    checkOutput("clrEnOverlap", overlapCnt, 0);
    checkOutput("busyErrors", busyErrCnt, 0);

    if (pokeStart) begin
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      checkOutput("startInDoneIgnored", allOutputs(), 0);
    end
    i_mac_ready = 1'b1;
    @(negedge clk);
  endtask

  // Aborts a 4x4 run with reset while in INNER, then checks a clean follow-up run.
  task automatic resetMidRun();
    int cyc;
    @(negedge clk);
    i_size_x = 5'd4; i_size_y = 5'd4; i_start = 1'b1; i_mac_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
    end while (!(o_mac_valid && cyc > 4) && cyc < 40);
    checkOutput("reachedInner", int'(o_mac_valid), 1);
    rstn = 1'b0;
    #1;
    checkOutput("outputsAfterMidReset", allOutputs(), 0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(2, 2, 0, 1'b1);
  endtask

  initial begin
    int nx, ny;
    rstn = 1'b0; i_start = 1'b0; i_size_x = '0; i_size_y = '0; i_mac_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", allOutputs(), 0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("idleOutputs", allOutputs(), 0);

    applyStimulus(3, 3, 0, 1'b0);
    applyStimulus(1, 1, 0, 1'b0);
    applyStimulus(5, 4, 1, 1'b0);
    applyStimulus(0, 7, 0, 1'b0);
    applyStimulus(4, 0, 0, 1'b0);
    applyStimulus(31, 31, 0, 1'b0);
    applyStimulus(31, 2, 2, 1'b0);
    resetMidRun();
    for (int r = 0; r < 8; r++) begin
      nx = $urandom_range(0, 12);
      ny = $urandom_range(0, 12);
      applyStimulus(nx, ny, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/conv_same_idx_seq.md
# conv_same_idx_seq

Index sequencer for the 1-D convolution datapath in "same" output mode. It walks every output sample and, for each one, every valid (x, y) operand pair. It drives the operand read addresses and the MAC handshake. When each output sample completes, it issues the value, enable and clear controls for the downstream same-index register. It sits directly upstream of that register and of the MAC/accumulator.

## Interface
Parameters: none. Widths are fixed at 5-bit sizes and indexes, for lengths up to 31.

- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request. Sampled only in IDLE; ignored while busy.
- size_x  in  5  length NX of x. Latched on the accepted start.
- size_y  in  5  length NY of y. Latched on the accepted start.
- mac_ready  in  1  MAC can accept an operand pair this cycle.
- x_addr  out  5  x read index j.
- y_addr  out  5  y read index i−j.
- mac_valid  out  1  x_addr/y_addr pair valid this cycle.
- acc_clr  out  1  clear the accumulator before a new output sample.
- same_ind_val  out  5  same-mode output index, equal to i − offset.
- same_ind_en  out  1  load same_ind_val into the same-index register.
- same_ind_clr  out  1  clear the same-index register.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Index arithmetic:
  - offset = (NY−1)>>1.
  - Full-convolution index i is 6 bits, in the range offset .. offset+NX−1.
  - jmin = (i ≥ NY−1) ? i−(NY−1) : 0.
  - jmax = min(i, NX−1).
  - y_addr = i−j, truncated to 5 bits; it never exceeds NY−1.
- FSM states: IDLE, SETUP, INNER, STORE, DONE. All outputs are decoded from registered state and counters. There are no combinational input-to-output paths.
- IDLE:
  - All outputs 0.
  - On start=1: latch NX and NY, set i=offset, go to SETUP.
  - If NX=0 or NY=0: go directly to DONE with no other activity.
- SETUP, 1 cycle:
  - acc_clr=1 and busy=1; load j=jmin; go to INNER.
  - same_ind_clr=1 only in the first SETUP of a sequence.
- INNER:
  - mac_valid=1 with x_addr=j, y_addr=i−j.
  - The pair transfers when mac_valid & mac_ready.
  - On a transfer with j==jmax: go to STORE. On a transfer otherwise: j++.
  - When mac_ready=0: addresses and j hold.
- STORE, 1 cycle:
  - same_ind_en=1 with same_ind_val=i−offset.
  - If i==offset+NX−1: go to DONE. Otherwise i++ and go to SETUP.
- DONE, 1 cycle: done=1, busy=0; go to IDLE.
- busy=1 in SETUP, INNER and STORE only.
- Reset at any time, including mid-sequence, forces IDLE.
- Reset values: all outputs 0, counters 0, latched sizes 0.
- A start asserted in DONE is ignored; start is accepted only in IDLE.

## Timing
- Let E0 be the edge that accepts start. Cycle 1 is the first cycle after E0, which is the first SETUP.
- The number of MACs for output i is n_i = jmax−jmin+1.
- With mac_ready held high, each output occupies n_i+2 cycles. done is high in cycle Σ(n_i+2)+1.
- Each cycle with mac_ready=0 during INNER adds exactly one cycle.
- same_ind_en pulses once per output, NX times in total. same_ind_val increments 0,1,…,NX−1 across those pulses.
- same_ind_clr and same_ind_en are never high in the same cycle.
- For NX=0 or NY=0: done is high in cycle 1; there is no busy, no mac_valid and no same_ind_clr.

## Test plan
- NX=3, NY=3, mac_ready=1:
  - (x_addr, y_addr) sequence is (0,1)(1,0) | (0,2)(1,1)(2,0) | (1,2)(2,1).
  - same_ind_val is 0, 1, 2 on the same_ind_en pulses.
  - done is high in cycle 14.
- NX=1, NY=1: a single pair (0,0), same_ind_val=0, done in cycle 4.
- NX=5, NY=4 (offset=1), with mac_ready toggling 1/0 every cycle in INNER:
  - Pairs match the no-stall order exactly, with no duplicates.
  - Completion is delayed by one cycle per low-ready cycle.
- NX=0, NY=7: done in cycle 1; mac_valid, same_ind_en and same_ind_clr stay 0.
- NX=31, NY=31, mac_ready=1:
  - i spans 15..45; max y_addr is 30.
  - same_ind_val reaches 30 with no width wrap.
  - Total MAC count equals Σn_i.
- rstn pulsed low mid-INNER during a 4×4 run:
  - All outputs are 0 immediately.
  - A following start with NX=2, NY=2 runs cleanly.
  - A second start while busy has no effect.
